// File: rtl/tomasulo_fetch_issue.sv
// Tomasulo front end: 16-word instruction store, decode and in-order issue with
// register renaming through a small ROB, CDB capture and in-order commit.
module tomasulo_fetch_issue #(
    parameter int DATA_W      = 16,
    parameter int ROB_ENTRIES = 8,
    localparam int TAG_W      = $clog2(ROB_ENTRIES)
) (
    input  logic              clk1,
    input  logic              rst,
    input  logic              prog_we,
    input  logic [3:0]        prog_addr,
    input  logic [15:0]       prog_data,
    input  logic [3:0]        pc,
    input  logic              pc_valid,
    output logic              stall,
    output logic              issued,
    output logic              illegal,
    output logic [3:0]        iss_func,
    output logic [TAG_W-1:0]  iss_tag,
    output logic [1:0]        iss_class,
    output logic [1:0]        iss_slot,
    output logic [3:0]        iss_imm,
    output logic [DATA_W-1:0] src1_val,
    output logic [DATA_W-1:0] src2_val,
    output logic [DATA_W-1:0] src3_val,
    output logic [TAG_W-1:0]  src1_tag,
    output logic [TAG_W-1:0]  src2_tag,
    output logic [TAG_W-1:0]  src3_tag,
    output logic              src1_rdy,
    output logic              src2_rdy,
    output logic              src3_rdy,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_data,
    input  logic              commit_req,
    output logic              commit_valid,
    output logic [3:0]        commit_rd,
    output logic [DATA_W-1:0] commit_data,
    input  logic [11:0]       rs_release,
    output logic [TAG_W:0]    rob_count
);
    localparam int CNT_W = TAG_W + 1;
    localparam logic [TAG_W:0] ROB_FULL = CNT_W'(ROB_ENTRIES);
    localparam logic [1:0] CLS_ADD = 2'd0;
    localparam logic [1:0] CLS_MUL = 2'd1;
    localparam logic [1:0] CLS_BR  = 2'd2;
    localparam logic [1:0] CLS_LSQ = 2'd3;

    typedef struct packed {
        logic              busy;
        logic              ready;
        logic              writes_rd;
        logic [3:0]        rd;
        logic [DATA_W-1:0] value;
    } rob_entry_t;

    typedef struct packed {
        logic              pending;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] value;
    } reg_entry_t;

    logic [15:0]       imem_q [16];
    rob_entry_t        rob_q [ROB_ENTRIES];
    rob_entry_t        rob_d [ROB_ENTRIES];
    reg_entry_t        reg_q [16];
    reg_entry_t        reg_d [16];
    logic [TAG_W-1:0]  head_q, head_d, tail_q, tail_d;
    logic [TAG_W:0]    count_q, count_d;
    logic [11:0]       slot_busy_q, slot_busy_d;

    logic              issued_q, issued_d, illegal_q, illegal_d;
    logic [3:0]        iss_func_q, iss_func_d, iss_imm_q, iss_imm_d;
    logic [TAG_W-1:0]  iss_tag_q, iss_tag_d;
    logic [1:0]        iss_class_q, iss_class_d, iss_slot_q, iss_slot_d;
    logic [DATA_W-1:0] src_val_q [3];
    logic [DATA_W-1:0] src_val_d [3];
    logic [TAG_W-1:0]  src_tag_q [3];
    logic [TAG_W-1:0]  src_tag_d [3];
    logic [2:0]        src_rdy_q, src_rdy_d;
    logic              commit_valid_q, commit_valid_d;
    logic [3:0]        commit_rd_q, commit_rd_d;
    logic [DATA_W-1:0] commit_data_q, commit_data_d;

    logic [15:0]       instr;
    logic [3:0]        func, rs1, rs2, rd;
    logic              legal, writes_rd, is_store;
    logic [1:0]        cls, slot_idx;
    logic [3:0]        cls_busy, slot_base;
    logic              slot_found, do_issue, do_commit;
    logic [3:0]        src_reg [3];
    logic [DATA_W-1:0] op_val [3];
    logic [TAG_W-1:0]  op_tag [3];
    logic [2:0]        op_rdy;
    rob_entry_t        head_e;

    always_comb begin
        // NOTE: every signal gets a default before any branch, so no latch can be inferred.
        instr      = imem_q[pc];
        func       = instr[15:12];
        rs1        = instr[11:8];
        rs2        = instr[7:4];
        rd         = instr[3:0];
        legal      = ~func[3];
        writes_rd  = (func <= 4'd4);
        is_store   = (func == 4'd5);
        cls        = CLS_BR;
        slot_base  = 4'd6;
        cls_busy   = {2'b11, slot_busy_q[7:6]};
        case (func[2:1])
            2'b00: begin cls = CLS_ADD; slot_base = 4'd0; cls_busy = {1'b1, slot_busy_q[2:0]}; end
            2'b01: begin cls = CLS_MUL; slot_base = 4'd3; cls_busy = {1'b1, slot_busy_q[5:3]}; end
            2'b10: begin cls = CLS_LSQ; slot_base = 4'd8; cls_busy = slot_busy_q[11:8]; end
            default: ;
        endcase
        // Scanning downwards leaves the lowest free index as the final pick.
        slot_found = 1'b0;
        slot_idx   = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!cls_busy[i]) begin
                slot_found = 1'b1;
                slot_idx   = 2'(i);
            end
        end
        do_issue  = pc_valid & legal & (count_q != ROB_FULL) & slot_found;
        stall     = pc_valid & legal & ~do_issue;
        do_commit = commit_req & rob_q[head_q].busy & rob_q[head_q].ready;
    end

    // Operands are looked up in pre-edge state, so rd==rs1 sees the old mapping.
    always_comb begin
        src_reg[0] = rs1;
        src_reg[1] = rs2;
        src_reg[2] = rd;
        for (int s = 0; s < 3; s++) begin
            op_val[s] = '0;
            op_tag[s] = '0;
            op_rdy[s] = 1'b0;
            if (!reg_q[src_reg[s]].pending) begin
                op_val[s] = reg_q[src_reg[s]].value;
                op_rdy[s] = 1'b1;
            end else begin
                op_tag[s] = reg_q[src_reg[s]].tag;
                if (rob_q[op_tag[s]].ready) begin
                    op_val[s] = rob_q[op_tag[s]].value;
                    op_rdy[s] = 1'b1;
                end else if (cdb_valid && cdb_tag == op_tag[s]) begin
                    op_val[s] = cdb_data;
                    op_rdy[s] = 1'b1;
                end
            end
        end
        if (!is_store) begin
            op_val[2] = '0;
            op_tag[2] = '0;
            op_rdy[2] = 1'b0;
        end
    end

    always_comb begin
        rob_d          = rob_q;
        reg_d          = reg_q;
        head_d         = head_q;
        tail_d         = tail_q;
        slot_busy_d    = slot_busy_q & ~rs_release;
        head_e         = rob_q[head_q];
        issued_d       = 1'b0;
        illegal_d      = pc_valid & ~legal;
        iss_func_d     = iss_func_q;
        iss_tag_d      = iss_tag_q;
        iss_class_d    = iss_class_q;
        iss_slot_d     = iss_slot_q;
        iss_imm_d      = iss_imm_q;
        src_val_d      = src_val_q;
        src_tag_d      = src_tag_q;
        src_rdy_d      = src_rdy_q;
        commit_valid_d = 1'b0;
        commit_rd_d    = commit_rd_q;
        commit_data_d  = commit_data_q;

        if (cdb_valid && rob_q[cdb_tag].busy) begin
            rob_d[cdb_tag].ready = 1'b1;
            rob_d[cdb_tag].value = cdb_data;
        end

        if (do_commit) begin
            if (head_e.writes_rd) begin
                reg_d[head_e.rd].value = head_e.value;
                if (reg_q[head_e.rd].pending && reg_q[head_e.rd].tag == head_q)
                    reg_d[head_e.rd].pending = 1'b0;
            end
            rob_d[head_q]  = '0;
            head_d         = head_q + 1'b1;
            commit_valid_d = 1'b1;
            commit_rd_d    = head_e.rd;
            commit_data_d  = head_e.value;
        end

        // Issue is applied after commit so a same-edge rename of rd wins.
        if (do_issue) begin
            rob_d[tail_q] = '{busy: 1'b1, ready: 1'b0, writes_rd: writes_rd, rd: rd, value: '0};
            tail_d        = tail_q + 1'b1;
            slot_busy_d[slot_base + {2'b00, slot_idx}] = 1'b1;
            if (writes_rd) begin
                reg_d[rd].tag     = tail_q;
                reg_d[rd].pending = 1'b1;
            end
            issued_d    = 1'b1;
            iss_func_d  = func;
            iss_tag_d   = tail_q;
            iss_class_d = cls;
            iss_slot_d  = slot_idx;
            iss_imm_d   = rd;
            src_val_d   = op_val;
            src_tag_d   = op_tag;
            src_rdy_d   = op_rdy;
        end

        count_d = count_q + CNT_W'(do_issue) - CNT_W'(do_commit);
    end

    // NOTE: the instruction store has no reset; a loaded program survives rst.
    always_ff @(posedge clk1) begin
        if (prog_we) imem_q[prog_addr] <= prog_data;
    end

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ROB_ENTRIES; i++) rob_q[i] <= '0;
            for (int i = 0; i < 16; i++) reg_q[i] <= '{pending: 1'b0, tag: '0, value: DATA_W'(i)};
            for (int i = 0; i < 3; i++) begin
                src_val_q[i] <= '0;
                src_tag_q[i] <= '0;
            end
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            slot_busy_q    <= '0;
            issued_q       <= 1'b0;
            illegal_q      <= 1'b0;
            iss_func_q     <= '0;
            iss_tag_q      <= '0;
            iss_class_q    <= '0;
            iss_slot_q     <= '0;
            iss_imm_q      <= '0;
            src_rdy_q      <= '0;
            commit_valid_q <= 1'b0;
            commit_rd_q    <= '0;
            commit_data_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            rob_q          <= rob_d;
            reg_q          <= reg_d;
            src_val_q      <= src_val_d;
            src_tag_q      <= src_tag_d;
            head_q         <= head_d;
            tail_q         <= tail_d;
            count_q        <= count_d;
            slot_busy_q    <= slot_busy_d;
            issued_q       <= issued_d;
            illegal_q      <= illegal_d;
            iss_func_q     <= iss_func_d;
            iss_tag_q      <= iss_tag_d;
            iss_class_q    <= iss_class_d;
            iss_slot_q     <= iss_slot_d;
            iss_imm_q      <= iss_imm_d;
            src_rdy_q      <= src_rdy_d;
            commit_valid_q <= commit_valid_d;
            commit_rd_q    <= commit_rd_d;
            commit_data_q  <= commit_data_d;
        end
    end

    assign issued       = issued_q;
    assign illegal      = illegal_q;
    assign iss_func     = iss_func_q;
    assign iss_tag      = iss_tag_q;
    assign iss_class    = iss_class_q;
    assign iss_slot     = iss_slot_q;
    assign iss_imm      = iss_imm_q;
    assign src1_val     = src_val_q[0];
    assign src2_val     = src_val_q[1];
    assign src3_val     = src_val_q[2];
    assign src1_tag     = src_tag_q[0];
    assign src2_tag     = src_tag_q[1];
    assign src3_tag     = src_tag_q[2];
    assign src1_rdy     = src_rdy_q[0];
    assign src2_rdy     = src_rdy_q[1];
    assign src3_rdy     = src_rdy_q[2];
    assign commit_valid = commit_valid_q;
    assign commit_rd    = commit_rd_q;
    assign commit_data  = commit_data_q;
    assign rob_count    = count_q;
endmodule

// File: tb/tb_tomasulo_fetch_issue.sv
// Directed bench for tomasulo_fetch_issue: hand-computed expectations for reset,
// issue/rename, CDB forwarding, commit, slot and ROB exhaustion, illegal ops and stores.
module tb_tomasulo_fetch_issue;
    logic        clk1 = 1'b0;
    logic        rst;
    logic        prog_we;
    logic [3:0]  prog_addr;
    logic [15:0] prog_data;
    logic [3:0]  pc;
    logic        pc_valid;
    logic        stall, issued, illegal;
    logic [3:0]  iss_func, iss_imm;
    logic [2:0]  iss_tag;
    logic [1:0]  iss_class, iss_slot;
    logic [15:0] src1_val, src2_val, src3_val;
    logic [2:0]  src1_tag, src2_tag, src3_tag;
    logic        src1_rdy, src2_rdy, src3_rdy;
    logic        cdb_valid;
    logic [2:0]  cdb_tag;
    logic [15:0] cdb_data;
    logic        commit_req;
    logic        commit_valid;
    logic [3:0]  commit_rd;
    logic [15:0] commit_data;
    logic [11:0] rs_release;
    logic [3:0]  rob_count;

    int n_checks = 0;
    int n_errors = 0;

    // 0:add r3=r1+r2  1:mul r5=r3*r4  2:illegal  3:store r7->[r1+r2]
    // 4:add r6=r4+r5  5:add r9=r7+r8  6:add r11=r9+r10  7:add r12=r11+r9  8:beq r1,r2,+5
    logic [15:0] prog [9] = '{16'h0123, 16'h2345, 16'h8000, 16'h5127, 16'h0456,
                              16'h0789, 16'h09AB, 16'h0B9C, 16'h6125};

    tomasulo_fetch_issue #(.DATA_W(16), .ROB_ENTRIES(8)) dut (
        .clk1(clk1), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .pc(pc), .pc_valid(pc_valid), .stall(stall), .issued(issued), .illegal(illegal),
        .iss_func(iss_func), .iss_tag(iss_tag), .iss_class(iss_class), .iss_slot(iss_slot),
        .iss_imm(iss_imm), .src1_val(src1_val), .src2_val(src2_val), .src3_val(src3_val),
        .src1_tag(src1_tag), .src2_tag(src2_tag), .src3_tag(src3_tag),
        .src1_rdy(src1_rdy), .src2_rdy(src2_rdy), .src3_rdy(src3_rdy),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .commit_req(commit_req), .commit_valid(commit_valid), .commit_rd(commit_rd),
        .commit_data(commit_data), .rs_release(rs_release), .rob_count(rob_count)
    );

    always #5 clk1 = ~clk1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk1);
        #1;
    endtask

    initial begin
        rst = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
        pc = '0; pc_valid = 1'b0; cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0;
        commit_req = 1'b0; rs_release = '0;

        for (int i = 0; i < 9; i++) begin
            prog_we = 1'b1; prog_addr = 4'(i); prog_data = prog[i];
            step();
        end
        prog_we = 1'b0;

        check("rst_issued", issued, 0);
        check("rst_illegal", illegal, 0);
        check("rst_commit_valid", commit_valid, 0);
        check("rst_rob_count", rob_count, 0);
        check("rst_stall", stall, 0);
        check("rst_iss_tag", iss_tag, 0);
        check("rst_src1_val", src1_val, 0);
        check("rst_src1_rdy", src1_rdy, 0);
        check("rst_commit_data", commit_data, 0);
        rst = 1'b0;
        step();

        // First add: operands from the reset register values
        pc = 4'd0; pc_valid = 1'b1;
        step();
        pc_valid = 1'b0;
        check("add_issued", issued, 1);
        check("add_class", iss_class, 0);
        check("add_slot", iss_slot, 0);
        check("add_tag", iss_tag, 0);
        check("add_func", iss_func, 0);
        check("add_imm", iss_imm, 3);
        check("add_src1_val", src1_val, 1);
        check("add_src1_rdy", src1_rdy, 1);
        check("add_src2_val", src2_val, 2);
        check("add_src2_rdy", src2_rdy, 1);
        check("add_src3_rdy", src3_rdy, 0);
        check("add_rob_count", rob_count, 1);

        // Mul reads r3 while tag 0 is on the CDB
        pc = 4'd1; pc_valid = 1'b1; cdb_valid = 1'b1; cdb_tag = 3'd0; cdb_data = 16'h0003;
        step();
        pc_valid = 1'b0; cdb_valid = 1'b0;
        check("mul_issued", issued, 1);
        check("mul_tag", iss_tag, 1);
        check("mul_class", iss_class, 1);
        check("mul_func", iss_func, 2);
        check("mul_src1_val", src1_val, 3);
        check("mul_src1_rdy", src1_rdy, 1);
        check("mul_src1_tag", src1_tag, 0);
        check("mul_src2_val", src2_val, 4);
        check("mul_rob_count", rob_count, 2);

        commit_req = 1'b1;
        step();
        check("c1_valid", commit_valid, 1);
        check("c1_rd", commit_rd, 3);
        check("c1_data", commit_data, 3);
        check("c1_rob_count", rob_count, 1);
        check("c1_issued", issued, 0);
        check("c1_tag_hold", iss_tag, 1);
        step();
        commit_req = 1'b0;
        check("c2_valid", commit_valid, 0);
        check("c2_rob_count", rob_count, 1);

        // Asynchronous reset mid-operation
        rst = 1'b1;
        #2;
        check("mrst_rob_count", rob_count, 0);
        check("mrst_iss_tag", iss_tag, 0);
        check("mrst_commit_data", commit_data, 0);
        rst = 1'b0;
        step();

        // Exhaust the three add slots
        pc = 4'd4; pc_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("adds_issued%0d", k), issued, 1);
            check($sformatf("adds_tag%0d", k), iss_tag, 32'(k));
            check($sformatf("adds_slot%0d", k), iss_slot, 32'(k));
        end
        check("slots_full_stall", stall, 1);
        step();
        check("slots_full_issued", issued, 0);
        check("slots_full_rob_count", rob_count, 3);
        rs_release = 12'h001;
        #1;
        check("release_edge_stall", stall, 1);
        step();
        check("release_edge_issued", issued, 0);
        rs_release = 12'h000;
        #1;
        check("after_release_stall", stall, 0);
        step();
        check("reuse_issued", issued, 1);
        check("reuse_slot", iss_slot, 0);
        check("reuse_tag", iss_tag, 3);
        check("reuse_rob_count", rob_count, 4);

        // Fill the ROB
        pc_valid = 1'b0; rs_release = 12'hFFF;
        step();
        pc_valid = 1'b1;
        for (int k = 4; k < 8; k++) begin
            step();
            check($sformatf("fill_issued%0d", k), issued, 1);
            check($sformatf("fill_tag%0d", k), iss_tag, 32'(k));
        end
        check("full_rob_count", rob_count, 8);
        #1;
        check("full_stall", stall, 1);
        cdb_valid = 1'b1; cdb_tag = 3'd0; cdb_data = 16'h00AA;
        step();
        cdb_valid = 1'b0;
        check("full_issued", issued, 0);
        check("full_rob_count2", rob_count, 8);
        commit_req = 1'b1;
        #1;
        check("commit_full_stall", stall, 1);
        step();
        commit_req = 1'b0;
        check("commit_full_valid", commit_valid, 1);
        check("commit_full_rd", commit_rd, 6);
        check("commit_full_data", commit_data, 16'h00AA);
        check("commit_full_issued", issued, 0);
        check("commit_full_rob_count", rob_count, 7);
        #1;
        check("wrap_stall", stall, 0);
        step();
        check("wrap_issued", issued, 1);
        check("wrap_tag", iss_tag, 0);
        check("wrap_rob_count", rob_count, 8);

        // Illegal opcode is consumed even with a full ROB
        pc = 4'd2;
        #1;
        check("illegal_stall", stall, 0);
        step();
        pc_valid = 1'b0;
        check("illegal_pulse", illegal, 1);
        check("illegal_issued", issued, 0);
        check("illegal_rob_count", rob_count, 8);
        step();
        check("illegal_clear", illegal, 0);
        rs_release = 12'h000;

        rst = 1'b1;
        step();
        rst = 1'b0;
        step();

        // Store returns r7 on src3 and does not rename r7
        pc = 4'd3; pc_valid = 1'b1;
        step();
        check("st_issued", issued, 1);
        check("st_class", iss_class, 3);
        check("st_slot", iss_slot, 0);
        check("st_tag", iss_tag, 0);
        check("st_func", iss_func, 5);
        check("st_src1_val", src1_val, 1);
        check("st_src2_val", src2_val, 2);
        check("st_src3_val", src3_val, 7);
        check("st_src3_rdy", src3_rdy, 1);
        check("st_rob_count", rob_count, 1);
        pc = 4'd5;
        step();
        check("r7_tag", iss_tag, 1);
        check("r7_class", iss_class, 0);
        check("r7_src1_val", src1_val, 7);
        check("r7_src1_rdy", src1_rdy, 1);
        check("r7_src1_tag", src1_tag, 0);
        check("r7_src2_val", src2_val, 8);
        check("r7_src3_val", src3_val, 0);
        check("r7_src3_rdy", src3_rdy, 0);

        // Ready ROB value forwarded, then an unready producer
        pc_valid = 1'b0; cdb_valid = 1'b1; cdb_tag = 3'd1; cdb_data = 16'h1234;
        step();
        cdb_valid = 1'b0;
        pc = 4'd6; pc_valid = 1'b1;
        step();
        check("robfwd_tag", iss_tag, 2);
        check("robfwd_src1_val", src1_val, 16'h1234);
        check("robfwd_src1_rdy", src1_rdy, 1);
        check("robfwd_src1_tag", src1_tag, 1);
        check("robfwd_src2_val", src2_val, 16'h000A);
        pc = 4'd7;
        step();
        check("wait_tag", iss_tag, 3);
        check("wait_src1_rdy", src1_rdy, 0);
        check("wait_src1_val", src1_val, 0);
        check("wait_src1_tag", src1_tag, 2);
        check("wait_src2_val", src2_val, 16'h1234);
        check("wait_src2_rdy", src2_rdy, 1);

        // Branch class
        pc = 4'd8;
        step();
        pc_valid = 1'b0;
        check("br_class", iss_class, 2);
        check("br_slot", iss_slot, 0);
        check("br_tag", iss_tag, 4);
        check("br_imm", iss_imm, 5);
        check("br_func", iss_func, 6);
        check("br_rob_count", rob_count, 5);
        step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/tomasulo_fetch_issue.md
Name: tomasulo_fetch_issue

Overview:
- Front end of the Tomasulo core: a 16-entry instruction memory indexed by pc, decode of 16-bit instructions, and in-order issue.
- Issue allocates a ROB entry and a reservation-station or load/store-queue slot, renames the destination register and supplies operand values or tags.
- Tracks CDB writebacks and in-order commit to the register bank.
- Sits between the pc generator and the execution units.

Parameters:
- DATA_W, 16, register/ROB data width.
- ROB_ENTRIES, 8, ROB depth; power of two; tag width is log2 (3).

Ports:
- clk1  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- prog_we  in  1  write instruction memory.
- prog_addr  in  4  instruction memory write address.
- prog_data  in  16  instruction word.
- pc  in  4  fetch address.
- pc_valid  in  1  request to issue the instruction at pc.
- stall  out  1  combinational; pc_valid=1 but resources are unavailable. Driver holds pc.
- issued  out  1  registered; one instruction was issued last edge.
- illegal  out  1  registered; pc_valid with func 8..15 was consumed as a NOP.
- iss_func  out  4  opcode of the issued instruction.
- iss_tag  out  3  allocated ROB tag.
- iss_class  out  2  0=add/sub, 1=mul/div, 2=branch, 3=load/store.
- iss_slot  out  2  allocated slot in that class.
- iss_imm  out  4  rd field; branch offset for branches.
- src1_val/src2_val/src3_val  out  DATA_W each  operand value.
- src1_tag/src2_tag/src3_tag  out  3 each  producer tag.
- src1_rdy/src2_rdy/src3_rdy  out  1 each  operand ready.
- cdb_valid  in  1  CDB broadcast.
- cdb_tag  in  3  ROB tag being written.
- cdb_data  in  DATA_W  result.
- commit_req  in  1  retire ROB head if ready.
- commit_valid  out  1  registered; an entry retired.
- commit_rd  out  4  retired destination register.
- commit_data  out  DATA_W  retired value.
- rs_release  in  12  slot free mask: [2:0] add, [5:3] mul, [7:6] branch, [11:8] lsq.
- rob_count  out  4  occupied ROB entries, 0..8.

Behaviour:
- Instruction format: [15:12] func, [11:8] rs1, [7:4] rs2, [3:0] rd.
- Func 0 add, 1 sub, 2 mul, 3 div, 4 load, 5 store, 6 beq, 7 bneq.
- Load address is rs1+rs2; load writes rd.
- Store address is rs1+rs2; store data is reg rd, returned on src3.
- Branches compare rs1 and rs2; the rd field is the immediate.
- Instruction memory: 16x16, written at the clock edge, read combinationally at pc. A same-cycle read returns the old word. Contents are not cleared by reset.
- Issue condition: pc_valid, legal func, ROB not full, and a free slot in the class. All checks use state before this edge's commit and release.
- Slot selection: lowest-index free slot.
- On issue at the edge:
  - Allocate ROB[tail]: busy=1, ready=0, rd, writes_rd = (func in 0..4).
  - tail increments and wraps 7->0.
  - The slot is marked busy.
- Operand lookup per source register:
  - No pending tag: regbank value, rdy=1.
  - Tag with ROB entry ready: ROB value, rdy=1.
  - Tag matching cdb_tag this cycle with cdb_valid: cdb_data, rdy=1.
  - Otherwise: tag, rdy=0, val=0.
- src3 is used by stores only; otherwise its val, tag and rdy outputs are 0.
- Operands are read before renaming, so rd==rs1 sees the old mapping.
- Renaming: if writes_rd, regbank[rd].tag=new tag and pending=1.
- Issue outputs are registered. When nothing issues, issued=0 and the remaining fields hold.
- Illegal func: not stalled, pulses illegal, allocates nothing.
- CDB: sets ROB[cdb_tag] value and ready=1 if that entry is busy; otherwise ignored.
- Commit: commit_req with head busy and ready does the following:
  - Writes regbank[rd] if writes_rd.
  - Clears the pending tag only if it equals the head tag and the same-edge issue did not rename rd (issue wins).
  - Frees the head entry; head wraps 7->0.
  - Pulses commit_valid with rd and value.
- commit_req on an empty or not-ready head: commit_valid=0, no change.
- Release: clears busy for mask bits at the edge. Releasing an already-free slot is harmless.
- rob_count updates with issue and commit; simultaneous issue and commit keep it constant.
- Reset: ROB empty, head=tail=0, all slots free, regbank value[i]=i, all tags cleared, every output 0.
- Reset mid-operation discards all in-flight state.

Test Plan:
1. Assert rst -> all outputs 0, rob_count=0, stall=0.
2. mem[0]=0x0123, pc=0, pc_valid for one cycle -> issued=1, iss_class=0, iss_slot=0, iss_tag=0, src1_val=1/rdy, src2_val=2/rdy, rob_count=1.
3. Then mem[1]=0x2345 issued while cdb_valid with tag 0 and data 0x0003 in the same cycle -> src1_val=3/rdy, iss_class=1, iss_tag=1. Then commit_req twice -> first commit_valid with rd=3, data=3; second commit_valid=0 (head not ready).
4. Four adds with no release -> fourth cycle stall=1, issued=0. Set rs_release[0] -> next edge issues slot 0.
5. Eight issues with no commit -> rob_count=8 and the ninth stalls. Commit plus issue in the same cycle -> still stalls that cycle; tag 0 is reused next, proving wrap.
6. mem[2]=0x8000 -> illegal=1, issued=0, rob_count unchanged. Store 0x5127 -> src3 carries r7, iss_class=3, r7 not renamed.
